// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: a stall vector with fixed priority, a 32-cycle
// mult/div sequencer, and exception/eret redirects with instruction-fetch draining.
`timescale 1ns/1ps

module pipeline_ctrl (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        if_inst_wait_i,
    input  logic        id_load_use_i,
    input  logic        ex_muldiv_req_i,
    input  logic        mem_data_wait_i,
    input  logic        mem_exception_i,
    input  logic [31:0] mem_exception_type_i,
    input  logic [31:0] cp0_epc_i,
    output logic [3:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] flush_pc_o,
    output logic        muldiv_busy_o,
    output logic        muldiv_done_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MULDIV = 2'd1,
        DRAIN  = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam logic [31:0] ERET_CODE  = 32'h0000_000e;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [5:0]  MULDIV_LEN = 6'd32;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] flush_pc_q, flush_pc_d;
    logic        flush_q, flush_d;
    logic        done_q, done_d;
    logic [31:0] exc_pc;
    state_t      exc_target;

    // A redirect must wait for any outstanding fetch to land before the flush.
    assign exc_pc     = (mem_exception_type_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    assign exc_target = if_inst_wait_i ? DRAIN : FLUSH;

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        flush_pc_d = flush_pc_q;
        done_d     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_exception_i) begin
                    flush_pc_d = exc_pc;
                    state_d    = exc_target;
                end else if (ex_muldiv_req_i) begin
                    count_d = MULDIV_LEN;
                    state_d = MULDIV;
                end
            end
            MULDIV: begin
                if (mem_exception_i) begin
                    count_d    = 6'd0;
                    flush_pc_d = exc_pc;
                    state_d    = exc_target;
                end else begin
                    count_d = count_q - 6'd1;
                    if (count_q == 6'd1) begin
                        done_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            DRAIN: begin
                if (!if_inst_wait_i) state_d = FLUSH;
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        flush_d = (state_d == FLUSH);
    end

    always_comb begin
        stall_o = 4'b0000;
        if (state_q == DRAIN)             stall_o = 4'b1111;
        else if (state_q == FLUSH)        stall_o = 4'b0000;
        else if (mem_data_wait_i)         stall_o = 4'b1111;
        else if (state_q == MULDIV)       stall_o = 4'b0111;
        else if (id_load_use_i)           stall_o = 4'b0011;
        else if (if_inst_wait_i)          stall_o = 4'b0001;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= RUN;
            count_q    <= 6'd0;
            flush_pc_q <= RESET_PC;
            flush_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            flush_pc_q <= flush_pc_d;
            flush_q    <= flush_d;
            done_q     <= done_d;
        end
    end

    assign flush_o       = flush_q;
    assign flush_pc_o    = flush_pc_q;
    assign muldiv_done_o = done_q;
    assign muldiv_busy_o = (state_q == MULDIV);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: stall-priority table, directed corner
// sequences and randomized traffic against a cycle-level behavioural model.
`timescale 1ns/1ps

module tb_pipeline_ctrl;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        if_inst_wait_i, id_load_use_i, ex_muldiv_req_i;
    logic        mem_data_wait_i, mem_exception_i;
    logic [31:0] mem_exception_type_i, cp0_epc_i;
    logic [3:0]  stall_o;
    logic        flush_o, muldiv_busy_o, muldiv_done_o;
    logic [31:0] flush_pc_o;

    always #5 clock_i = ~clock_i;

    pipeline_ctrl dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .if_inst_wait_i       (if_inst_wait_i),
        .id_load_use_i        (id_load_use_i),
        .ex_muldiv_req_i      (ex_muldiv_req_i),
        .mem_data_wait_i      (mem_data_wait_i),
        .mem_exception_i      (mem_exception_i),
        .mem_exception_type_i (mem_exception_type_i),
        .cp0_epc_i            (cp0_epc_i),
        .stall_o              (stall_o),
        .flush_o              (flush_o),
        .flush_pc_o           (flush_pc_o),
        .muldiv_busy_o        (muldiv_busy_o),
        .muldiv_done_o        (muldiv_done_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining mult/div cycles, a pending fetch drain,
    // and one-cycle flush/done pulses scheduled for the next cycle.
    int          m_busy_left;
    bit          m_drain, m_flush, m_done;
    logic [31:0] m_pc;

    logic [3:0]  obs_stall;
    logic        obs_flush, obs_busy, obs_done;
    logic [31:0] obs_pc;

    task automatic model_reset();
        m_busy_left = 0;
        m_drain     = 0;
        m_flush     = 0;
        m_done      = 0;
        m_pc        = 32'hBFC0_0000;
    endtask

    task automatic step(input logic dw, input logic lu, input logic iw, input logic mreq,
                        input logic exc, input logic [31:0] typ, input logic [31:0] epc);
        logic [3:0] exp_stall;
        bit nf, nd;
        @(negedge clock_i);
        mem_data_wait_i      = dw;
        id_load_use_i        = lu;
        if_inst_wait_i       = iw;
        ex_muldiv_req_i      = mreq;
        mem_exception_i      = exc;
        mem_exception_type_i = typ;
        cp0_epc_i            = epc;
        #1;
        if (m_flush)             exp_stall = 4'b0000;
        else if (m_drain)        exp_stall = 4'b1111;
        else if (dw)             exp_stall = 4'b1111;
        else if (m_busy_left > 0) exp_stall = 4'b0111;
        else if (lu)             exp_stall = 4'b0011;
        else if (iw)             exp_stall = 4'b0001;
        else                     exp_stall = 4'b0000;
        obs_stall = stall_o;
        obs_flush = flush_o;
        obs_busy  = muldiv_busy_o;
        obs_done  = muldiv_done_o;
        obs_pc    = flush_pc_o;
        check("stall", {28'd0, obs_stall}, {28'd0, exp_stall});
        check("flush", {31'd0, obs_flush}, {31'd0, m_flush});
        check("busy",  {31'd0, obs_busy},  {31'd0, m_busy_left > 0});
        check("done",  {31'd0, obs_done},  {31'd0, m_done});
        check("flush_pc", obs_pc, m_pc);
        @(posedge clock_i);
        nf = 0;
        nd = 0;
        if (m_flush) begin
        end else if (m_drain) begin
            if (!iw) begin
                m_drain = 0;
                nf      = 1;
            end
        end else if (exc) begin
            m_pc        = (typ == 32'h0000_000e) ? epc : 32'hBFC0_0380;
            m_busy_left = 0;
            if (iw) m_drain = 1;
            else    nf      = 1;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) nd = 1;
        end else if (mreq) begin
            m_busy_left = 32;
        end
        m_flush = nf;
        m_done  = nd;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clock_i);
        #2;
        {mem_data_wait_i, id_load_use_i, if_inst_wait_i, ex_muldiv_req_i, mem_exception_i} = '0;
        reset_i = 1'b1;
        #1;
        check({tag, "_stall"}, {28'd0, stall_o}, 32'd0);
        check({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
        check({tag, "_busy"},  {31'd0, muldiv_busy_o}, 32'd0);
        check({tag, "_done"},  {31'd0, muldiv_done_o}, 32'd0);
        check({tag, "_pc"},    flush_pc_o, 32'hBFC0_0000);
        model_reset();
        @(posedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    typedef struct {
        logic       dw, lu, iw;
        logic [3:0] stall;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0111, done_at, n_done, n_flush;
        vecs[0] = '{0, 0, 0, 4'b0000};
        vecs[1] = '{0, 0, 1, 4'b0001};
        vecs[2] = '{0, 1, 0, 4'b0011};
        vecs[3] = '{0, 1, 1, 4'b0011};
        vecs[4] = '{1, 0, 0, 4'b1111};
        vecs[5] = '{1, 0, 1, 4'b1111};
        vecs[6] = '{1, 1, 1, 4'b1111};
        vecs[7] = '{0, 1, 1, 4'b0011};

        reset_i = 1'b1;
        {mem_data_wait_i, id_load_use_i, if_inst_wait_i, ex_muldiv_req_i, mem_exception_i} = '0;
        mem_exception_type_i = '0;
        cp0_epc_i            = '0;
        model_reset();
        #1;
        check("rst_stall", {28'd0, stall_o}, 32'd0);
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_done",  {31'd0, muldiv_done_o}, 32'd0);
        check("rst_busy",  {31'd0, muldiv_busy_o}, 32'd0);
        check("rst_pc",    flush_pc_o, 32'hBFC0_0000);
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;

        // Stall priority in RUN, ending with all-waits then data wait dropped.
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].dw, vecs[i].lu, vecs[i].iw, 0, 0, 32'd0, 32'd0);
            check($sformatf("table_stall[%0d]", i), {28'd0, obs_stall}, {28'd0, vecs[i].stall});
        end

        // Mult/div: 32 stalled cycles, done in the 33rd.
        step(0, 0, 0, 1, 0, 32'd0, 32'd0);
        n0111   = 0;
        done_at = -1;
        for (int c = 1; c <= 40; c++) begin
            idle();
            if (obs_stall == 4'b0111) n0111++;
            if (obs_done && done_at < 0) done_at = c;
        end
        check("muldiv_stall_cycles", n0111, 32);
        check("muldiv_done_cycle", done_at, 33);

        // Plain exception, no fetch outstanding.
        step(0, 0, 0, 0, 1, 32'h4, 32'h1234_5678);
        idle();
        check("exc_flush", {31'd0, obs_flush}, 32'd1);
        check("exc_pc", obs_pc, 32'hBFC0_0380);
        check("exc_stall", {28'd0, obs_stall}, 32'd0);
        idle();
        check("exc_flush_drop", {31'd0, obs_flush}, 32'd0);

        // Eret while a fetch is outstanding for three cycles.
        step(0, 0, 1, 0, 1, 32'he, 32'hBFC0_1234);
        step(0, 0, 1, 0, 0, 32'd0, 32'd0);
        check("drain_stall0", {28'd0, obs_stall}, 32'hf);
        step(0, 0, 1, 0, 1, 32'h4, 32'd0);
        check("drain_stall1", {28'd0, obs_stall}, 32'hf);
        step(0, 0, 0, 0, 0, 32'd0, 32'd0);
        check("drain_stall2", {28'd0, obs_stall}, 32'hf);
        idle();
        check("eret_flush", {31'd0, obs_flush}, 32'd1);
        check("eret_pc", obs_pc, 32'hBFC0_1234);
        idle();

        // Exception at mult/div counter = 10.
        step(0, 0, 0, 1, 0, 32'd0, 32'd0);
        repeat (22) idle();
        step(0, 0, 0, 0, 1, 32'h8, 32'd0);
        check("abort_busy_before", {31'd0, obs_busy}, 32'd1);
        n_done = 0;
        idle();
        check("abort_busy_after", {31'd0, obs_busy}, 32'd0);
        check("abort_flush", {31'd0, obs_flush}, 32'd1);
        for (int c = 0; c < 15; c++) begin
            idle();
            if (obs_done) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // Reset mid-MULDIV, then mid-DRAIN.
        step(0, 0, 0, 1, 0, 32'd0, 32'd0);
        repeat (5) idle();
        async_reset("rst_muldiv");
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            idle();
            if (obs_done) n_done++;
        end
        check("rst_muldiv_no_done", n_done, 0);
        step(0, 0, 1, 0, 1, 32'h4, 32'd0);
        step(0, 0, 1, 0, 0, 32'd0, 32'd0);
        async_reset("rst_drain");
        n_flush = 0;
        for (int c = 0; c < 5; c++) begin
            idle();
            if (obs_flush) n_flush++;
        end
        check("rst_drain_no_flush", n_flush, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step($urandom % 4 == 0, $urandom % 4 == 0, $urandom % 3 == 0,
                 $urandom % 8 == 0, $urandom % 16 == 0,
                 ($urandom % 2 == 0) ? 32'he : ($urandom % 32), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port: clock_i  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: reset_i  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: if_inst_wait_i  in  1  instruction fetch outstanding on the bus.
REQ-004 SHALL have port: id_load_use_i  in  1  load-use hazard detected in ID.
REQ-005 SHALL have port: ex_muldiv_req_i  in  1  EX holds a multi-cycle mult/div; level, valid in RUN only.
REQ-006 SHALL have port: mem_data_wait_i  in  1  data access outstanding in MEM.
REQ-007 SHALL have port: mem_exception_i  in  1  MEM commits an exception or eret.
REQ-008 SHALL have port: mem_exception_type_i  in  32  cause code; 32'h0000000e = eret.
REQ-009 SHALL have port: cp0_epc_i  in  32  current EPC.
REQ-010 SHALL have port: stall_o  out  4  {data, exe, id, inst} stall vector to pipeline registers.
REQ-011 SHALL have port: flush_o  out  1  registered flush of all pipeline registers.
REQ-012 SHALL have port: flush_pc_o  out  32  registered redirect PC, valid while flush_o=1.
REQ-013 SHALL have port: muldiv_busy_o  out  1  mult/div sequence in progress.
REQ-014 SHALL have port: muldiv_done_o  out  1  one-cycle pulse; EX result valid.

Function
REQ-015 SHALL implement FSM with states RUN, MULDIV, DRAIN, FLUSH.
REQ-016 SHALL, in RUN with mem_exception_i=1: capture redirect PC; go to DRAIN if if_inst_wait_i=1, else FLUSH.
REQ-017 SHALL select redirect PC = cp0_epc_i when mem_exception_type_i=32'h0000000e, else 32'hBFC00380.
REQ-018 SHALL, in RUN with ex_muldiv_req_i=1 and mem_exception_i=0: load 6-bit counter with 32, go to MULDIV.
REQ-019 SHALL, in MULDIV: decrement counter each cycle, including cycles with mem_data_wait_i=1; at counter=1 pulse muldiv_done_o in the next cycle and return to RUN.
REQ-020 SHALL, in MULDIV with mem_exception_i=1: abort (counter to 0, no done pulse), capture PC, go to DRAIN/FLUSH per REQ-016.
REQ-021 SHALL, in DRAIN: drive stall_o=4'b1111; stay until if_inst_wait_i=0, then go to FLUSH; later mem_exception_i ignored.
REQ-022 SHALL, in FLUSH: assert flush_o for exactly one cycle with stall_o=4'b0000, then return to RUN.
REQ-023 SHALL drive stall_o combinationally with priority (state not DRAIN/FLUSH): mem_data_wait_i -> 4'b1111; else MULDIV -> 4'b0111; else id_load_use_i -> 4'b0011; else if_inst_wait_i -> 4'b0001; else 4'b0000.
REQ-024 SHALL assert muldiv_busy_o exactly while state=MULDIV.
REQ-025 SHALL not hold flush_o and any stall_o bit simultaneously.
REQ-026 SHALL give mem_exception_i priority over ex_muldiv_req_i when both arrive in the same RUN cycle.
REQ-027 SHALL hold flush_pc_o at its last captured value outside FLUSH.

Reset
REQ-028 SHALL, on reset_i=1 at any time, immediately set state=RUN, counter=0, flush_o=0, muldiv_done_o=0, flush_pc_o=32'hBFC00000.
REQ-029 SHALL abandon any MULDIV/DRAIN sequence on reset without emitting muldiv_done_o or flush_o.

Verification
REQ-030 SHALL cover: ex_muldiv_req_i pulse in RUN -> stall_o=4'b0111 for 32 cycles, muldiv_done_o high in cycle 33, stall_o=0 after.
REQ-031 SHALL cover: mem_exception_i, type 32'h4, if_inst_wait_i=0 -> next cycle flush_o=1, flush_pc_o=32'hBFC00380, stall_o=0; flush_o low after one cycle.
REQ-032 SHALL cover: eret (type 32'he, cp0_epc_i=32'hBFC01234) with if_inst_wait_i=1 for 3 cycles -> stall_o=4'b1111 for 3 cycles, then flush_o=1 with flush_pc_o=32'hBFC01234.
REQ-033 SHALL cover: exception at MULDIV counter=10 -> no muldiv_done_o, muldiv_busy_o drops, flush sequence follows.
REQ-034 SHALL cover: simultaneous mem_data_wait_i, id_load_use_i, if_inst_wait_i in RUN -> stall_o=4'b1111; drop data wait -> 4'b0011.
REQ-035 SHALL cover: reset_i asserted mid-MULDIV and mid-DRAIN -> outputs at reset values asynchronously, no pulse after release.
